// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared registered LC-3b ALU; owns the condition codes.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req0_shiftop,
  input  logic [3:0]       req0_amount,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ldcc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [1:0]       req1_shiftop,
  input  logic [3:0]       req1_amount,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ldcc,
  output logic [1:0]       alu_opval,
  output logic [1:0]       alu_shiftop,
  output logic [3:0]       alu_amount4,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_p,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             cc_n,
  output logic             cc_z,
  output logic             cc_p
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t state;
  logic   grant0, grant1;
  logic   hold_ldcc, hold_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  logic ptr;

  // ptr names the preferred requester; a lone valid requester wins regardless
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~ptr);
    grant1 = req1_valid & (~req0_valid | ptr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= 1'b0;
    else if (req0_ready | req1_ready)
      ptr <= req0_ready;
  end
`endif

  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
  end

  // alu_* are the holding registers themselves, so they stay stable through ISSUE and CAPT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alu_opval   <= '0;
      alu_shiftop <= '0;
      alu_amount4 <= '0;
      alu_a1      <= '0;
      alu_a2      <= '0;
      hold_ldcc   <= 1'b0;
      hold_id     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      cc_n        <= 1'b0;
      cc_z        <= 1'b1;
      cc_p        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_opval   <= req0_op;
            alu_shiftop <= req0_shiftop;
            alu_amount4 <= req0_amount;
            alu_a1      <= req0_a;
            alu_a2      <= req0_b;
            hold_ldcc   <= req0_ldcc;
            hold_id     <= 1'b0;
            state       <= ISSUE;
          end else if (req1_ready) begin
            alu_opval   <= req1_op;
            alu_shiftop <= req1_shiftop;
            alu_amount4 <= req1_amount;
            alu_a1      <= req1_a;
            alu_a2      <= req1_b;
            hold_ldcc   <= req1_ldcc;
            hold_id     <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= alu_d;
          rsp_id    <= hold_id;
          if (hold_ldcc) begin
            cc_n <= alu_n;
            cc_z <= alu_z;
            cc_p <= alu_p;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, cycle-counting scoreboard model and directed vectors.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req0_shiftop = '0, req1_op = '0, req1_shiftop = '0;
  logic [3:0]  req0_amount = '0, req1_amount = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ldcc = 1'b0, req1_ldcc = 1'b0;
  logic [1:0]  alu_opval, alu_shiftop;
  logic [3:0]  alu_amount4;
  logic [15:0] alu_a1, alu_a2;
  logic [15:0] alu_d = '0;
  logic        alu_n = 1'b0, alu_z = 1'b0, alu_p = 1'b0;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        cc_n, cc_z, cc_p;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_shiftop(req0_shiftop), .req0_amount(req0_amount), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ldcc(req0_ldcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_shiftop(req1_shiftop), .req1_amount(req1_amount), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ldcc(req1_ldcc),
    .alu_opval(alu_opval), .alu_shiftop(alu_shiftop), .alu_amount4(alu_amount4),
    .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_d(alu_d),
    .alu_n(alu_n), .alu_z(alu_z), .alu_p(alu_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p)
  );

  always #5 clk = ~clk;

  // Returns {n, z, p, result}; reserved shift code passes A through
  function automatic logic [18:0] alu_f(input logic [1:0] op, input logic [1:0] sh,
                                        input logic [3:0] amt, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a & b;
      2'b10: r = a ^ b;
      default: begin
        case (sh)
          2'b00: r = a << amt;
          2'b01: r = a >> amt;
          2'b11: r = $signed(a) >>> amt;
          default: r = a;
        endcase
      end
    endcase
    return {r[15], (r == 16'd0), (!r[15] && r != 16'd0), r};
  endfunction

  always @(posedge clk)
    {alu_n, alu_z, alu_p, alu_d} <= alu_f(alu_opval, alu_shiftop, alu_amount4, alu_a1, alu_a2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard model: each accepted request yields one response exactly 3 cycles later
  typedef struct {
    int          due;
    logic        id;
    logic [15:0] data;
    logic        ldcc;
    logic [2:0]  nzp;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          free_at = 0;
  logic        ptr = 1'b0;
  logic        m_rv = 1'b0, m_id = 1'b0;
  logic [15:0] m_data = '0;
  logic [2:0]  m_cc = 3'b010;
  logic [7:0]  m_ctl = '0;
  logic [15:0] m_a1 = '0, m_a2 = '0;

  always @(negedge clk) begin
    logic g0, g1;
    ent_t e;
    logic [18:0] res;
    cyc++;
    if (reset) begin
      q.delete();
      ptr = 1'b0; free_at = cyc;
      m_rv = 1'b0; m_id = 1'b0; m_data = '0; m_cc = 3'b010;
      m_ctl = '0; m_a1 = '0; m_a2 = '0;
    end else begin
      m_rv = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        m_rv = 1'b1; m_id = e.id; m_data = e.data;
        if (e.ldcc) m_cc = e.nzp;
      end
    end
    g0 = 1'b0; g1 = 1'b0;
    if (cyc >= free_at) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g0 = req0_valid;
      g1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        g0 = !ptr; g1 = ptr;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
`endif
    end
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    chk("m_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    chk("m_rsp_data", {16'd0, rsp_data}, {16'd0, m_data});
    chk("m_cc", {29'd0, cc_n, cc_z, cc_p}, {29'd0, m_cc});
    chk("m_alu_ctl", {24'd0, alu_opval, alu_shiftop, alu_amount4}, {24'd0, m_ctl});
    chk("m_alu_a1", {16'd0, alu_a1}, {16'd0, m_a1});
    chk("m_alu_a2", {16'd0, alu_a2}, {16'd0, m_a2});
    if (!reset && (g0 || g1)) begin
      if (g0) begin
        m_ctl = {req0_op, req0_shiftop, req0_amount}; m_a1 = req0_a; m_a2 = req0_b;
        e.ldcc = req0_ldcc; e.id = 1'b0;
      end else begin
        m_ctl = {req1_op, req1_shiftop, req1_amount}; m_a1 = req1_a; m_a2 = req1_b;
        e.ldcc = req1_ldcc; e.id = 1'b1;
      end
      res = alu_f(m_ctl[7:6], m_ctl[5:4], m_ctl[3:0], m_a1, m_a2);
      e.due = cyc + 3; e.data = res[15:0]; e.nzp = res[18:16];
      q.push_back(e);
      free_at = cyc + 3;
      ptr = g0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises valid and waits (bounded) for the handshake; returns at +1 of the ISSUE cycle
  task automatic send(input int p, input logic [1:0] op, input logic [1:0] sh,
                      input logic [3:0] amt, input logic [15:0] a, input logic [15:0] b,
                      input logic ld, output int waited);
    bit done = 0;
    waited = 0;
    if (p == 0) begin
      req0_op = op; req0_shiftop = sh; req0_amount = amt; req0_a = a; req0_b = b;
      req0_ldcc = ld; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_shiftop = sh; req1_amount = amt; req1_a = a; req1_b = b;
      req1_ldcc = ld; req1_valid = 1'b1;
    end
    for (int i = 0; i < 12 && !done; i++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) done = 1;
      else waited++;
      tick();
    end
    if (p == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    chk("send_handshake", {31'd0, done}, 32'd1);
  endtask

  // From +1 of ISSUE: expect silence in CAPT, then the tagged response
  task automatic expect_rsp(input string nm, input logic id, input logic [15:0] data,
                            input logic [2:0] cc);
    tick();
    chk({nm, "_no_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({nm, "_rsp_data"}, {16'd0, rsp_data}, {16'd0, data});
    chk({nm, "_cc"}, {29'd0, cc_n, cc_z, cc_p}, {29'd0, cc});
  endtask

  initial begin
    int w;
    int ng;
    logic g[3];
    logic [2:0] exp_g;

    repeat (2) tick();
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b010);
    reset = 1'b0;

    // ADD 3 + -3 -> zero
    send(0, 2'b00, 2'b00, 4'd0, 16'h0003, 16'hFFFD, 1'b1, w);
    chk("add_ready_after_reset", w, 32'd0);
    chk("add_alu_a1_issue", {16'd0, alu_a1}, 32'h0003);
    chk("add_alu_a2_issue", {16'd0, alu_a2}, 32'hFFFD);
    tick();
    chk("add_alu_a1_capt", {16'd0, alu_a1}, 32'h0003);
    chk("add_alu_a2_capt", {16'd0, alu_a2}, 32'hFFFD);
    chk("add_rsp_valid_capt", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("add_rsp_data", {16'd0, rsp_data}, 32'h0000);
    chk("add_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b010);
    tick();
    chk("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_data_holds", {16'd0, rsp_data}, 32'h0000);

    // Simultaneous held requests from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    req0_op = 2'b00; req0_shiftop = 2'b00; req0_amount = 4'd0;
    req0_a = 16'h0001; req0_b = 16'h0001; req0_ldcc = 1'b0;
    req1_op = 2'b10; req1_shiftop = 2'b00; req1_amount = 4'd0;
    req1_a = 16'h0005; req1_b = 16'h0003; req1_ldcc = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0;
    for (int c = 0; c < 15 && ng < 3; c++) begin
      #1;
      if (req0_ready) begin g[ng] = 1'b0; ng++; end
      else if (req1_ready) begin g[ng] = 1'b1; ng++; end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", ng, 32'd3);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = 3'b000;
`else
    exp_g = 3'b010;
`endif
    chk("grant_order", {29'd0, g[0], g[1], g[2]}, {29'd0, exp_g});
    repeat (3) tick();

    // Set cc to P, then a non-ldcc shift must leave it alone
    send(0, 2'b00, 2'b00, 4'd0, 16'h0001, 16'h0001, 1'b1, w);
    expect_rsp("add_p", 1'b0, 16'h0002, 3'b001);
    send(1, 2'b11, 2'b01, 4'd4, 16'h8000, 16'h0000, 1'b0, w);
    expect_rsp("rshfl", 1'b1, 16'h0800, 3'b001);

    // Accepted in the rsp_valid cycle of the previous operation
    send(0, 2'b10, 2'b00, 4'd0, 16'hFF00, 16'h0FF0, 1'b1, w);
    chk("b2b_ready_in_rsp_cycle", w, 32'd0);
    expect_rsp("xor_b2b", 1'b0, 16'hF0F0, 3'b100);

    // Arithmetic right shift and the reserved shift code
    send(1, 2'b11, 2'b11, 4'd4, 16'h8000, 16'h0000, 1'b1, w);
    expect_rsp("rshfa", 1'b1, 16'hF800, 3'b100);
    send(1, 2'b11, 2'b10, 4'd3, 16'h1234, 16'h0000, 1'b0, w);
    repeat (3) tick();

    // Request withdrawn before it is granted leaves no trace
    send(0, 2'b01, 2'b00, 4'd0, 16'h00F0, 16'h0FF0, 1'b0, w);
    req1_op = 2'b00; req1_a = 16'h7777; req1_b = 16'h1111; req1_ldcc = 1'b1;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();

    // Reset during CAPT of an AND from port 0
    send(0, 2'b01, 2'b00, 4'd0, 16'h00FF, 16'h0F0F, 1'b1, w);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_capt_cc", {29'd0, cc_n, cc_z, cc_p}, 32'b010);
    chk("rst_capt_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_next_grant_req0", {31'd0, req0_ready}, 32'd1);
    chk("rst_next_grant_req1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
